// File: rtl/disp_event_flags.sv
`default_nettype none
// ============================================================================
//  Module   : disp_event_flags
//  Brief    : Multi-channel sticky event flags for the display subsystem.
//             Each channel synchronises an asynchronous strobe into ACLK,
//             detects a selectable edge, and records it in a sticky flag, a
//             sticky overflow bit and a saturating counter. Flags are masked
//             and ORed into one registered interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module disp_event_flags #(
  parameter int NUM_CH      = 4,  // independent event channels (1..16)
  parameter int SYNC_STAGES = 2,  // synchroniser depth (>=2)
  parameter int CNT_W       = 4   // per-channel counter width (1..16)
) (
  input  logic                    ACLK,
  input  logic                    ARST,
  input  logic [NUM_CH-1:0]       EV_IN,
  input  logic [2*NUM_CH-1:0]     EDGE_SEL,
  input  logic [NUM_CH-1:0]       IRQ_EN,
  input  logic [NUM_CH-1:0]       CLR,
  output logic [NUM_CH-1:0]       FLAG,
  output logic [NUM_CH-1:0]       OVF,
  output logic [NUM_CH*CNT_W-1:0] CNT,
  output logic                    IRQ
);

  // Arm counter must reach SYNC_STAGES+1 before any detection is trusted.
  localparam int               ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Edge-select encodings; 2'b11 disables detection.
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]       sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0]       hist_q, hist_d;
  logic [ARM_W-1:0]        arm_q, arm_d;
  logic [NUM_CH-1:0]       flag_q, flag_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic                    irq_q, irq_d;

  logic [NUM_CH-1:0]       sync_s;
  logic [NUM_CH-1:0]       rise, fall, det;
  logic                    armed;
  logic [CNT_W-1:0]        cnt_cur;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q;
  assign fall   = ~sync_s & hist_q;
  assign armed  = (arm_q == ARM_MAX);

  // Per-channel edge qualification; history keeps tracking even when the
  // channel is disabled so that re-enabling never yields a stale edge.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0] mode;
      assign mode   = EDGE_SEL[2*i +: 2];
      assign det[i] = armed &&
                      (((mode == MODE_RISE) && rise[i]) ||
                       ((mode == MODE_FALL) && fall[i]) ||
                       ((mode == MODE_BOTH) && (rise[i] || fall[i])));
    end
  endgenerate

  // Synchroniser shift, edge history and arm-window counter.
  always_comb begin
    sync_d[0] = EV_IN;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    hist_d = sync_s;
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
  end

  // Flag/overflow/counter update; a detection in the clear cycle wins.
  always_comb begin
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    cnt_cur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_cur = cnt_q[CNT_W*i +: CNT_W];
      if (CLR[i]) begin
        flag_d[i]              = det[i];
        ovf_d[i]               = 1'b0;
        cnt_d[CNT_W*i +: CNT_W] = det[i] ? CNT_W'(1) : '0;
      end else if (det[i]) begin
        if (flag_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          flag_d[i] = 1'b1;
        end
        if (cnt_cur != CNT_MAX) begin
          cnt_d[CNT_W*i +: CNT_W] = cnt_cur + CNT_W'(1);
        end
      end
    end
    irq_d = |(flag_q & IRQ_EN);
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      hist_q <= '0;
      arm_q  <= '0;
      flag_q <= '0;
      ovf_q  <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      hist_q <= hist_d;
      arm_q  <= arm_d;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

  assign FLAG = flag_q;
  assign OVF  = ovf_q;
  assign CNT  = cnt_q;
  assign IRQ  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_event_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_event_flags
//  Brief    : Directed scoreboard bench for disp_event_flags (4 ch, 2 sync
//             stages, 4-bit counters). Stimulus pushes expected outputs; a
//             negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_event_flags;

  logic        ACLK;
  logic        ARST;
  logic [3:0]  EV_IN;
  logic [7:0]  EDGE_SEL;
  logic [3:0]  IRQ_EN;
  logic [3:0]  CLR;
  logic [3:0]  FLAG;
  logic [3:0]  OVF;
  logic [15:0] CNT;
  logic        IRQ;

  typedef struct {
    logic [3:0]  flag;
    logic [3:0]  ovf;
    logic [15:0] cnt;
    logic        irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  int    checks = 0;
  int    errors = 0;

  disp_event_flags #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .ACLK    (ACLK),
    .ARST    (ARST),
    .EV_IN   (EV_IN),
    .EDGE_SEL(EDGE_SEL),
    .IRQ_EN  (IRQ_EN),
    .CLR     (CLR),
    .FLAG    (FLAG),
    .OVF     (OVF),
    .CNT     (CNT),
    .IRQ     (IRQ)
  );

  // Free-running clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [3:0] f, input logic [3:0] o,
                          input logic [15:0] c, input logic i);
    exp_t e;
    e.flag = f;
    e.ovf  = o;
    e.cnt  = c;
    e.irq  = i;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    ARST = 1'b1;
    tick();
    push_exp("reset", 4'h0, 4'h0, 16'h0000, 1'b0);
    ARST = 1'b0;
    repeat (5) tick();
  endtask

  task automatic pulse(input int ch, input int len);
    EV_IN[ch] = 1'b1;
    repeat (len) tick();
    EV_IN[ch] = 1'b0;
    repeat (len) tick();
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge ACLK) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (FLAG !== mon_e.flag) begin
        errors++;
        $display("FAIL %s FLAG got %b exp %b", mon_n, FLAG, mon_e.flag);
      end
      checks++;
      if (OVF !== mon_e.ovf) begin
        errors++;
        $display("FAIL %s OVF got %b exp %b", mon_n, OVF, mon_e.ovf);
      end
      checks++;
      if (CNT !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s CNT got %h exp %h", mon_n, CNT, mon_e.cnt);
      end
      checks++;
      if (IRQ !== mon_e.irq) begin
        errors++;
        $display("FAIL %s IRQ got %b exp %b", mon_n, IRQ, mon_e.irq);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout got running exp finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed stimulus.
  initial begin
    ARST     = 1'b1;
    EV_IN    = 4'h0;
    EDGE_SEL = 8'h00;
    IRQ_EN   = 4'b0001;
    CLR      = 4'h0;
    tick();
    tick();

    // Reset latency: rise sampled at E, FLAG at E+2, IRQ at E+3.
    do_reset();
    EV_IN[0] = 1'b1;
    tick();
    push_exp("lat_E", 4'h0, 4'h0, 16'h0000, 1'b0);
    tick();
    push_exp("lat_E1", 4'h0, 4'h0, 16'h0000, 1'b0);
    tick();
    push_exp("lat_E2", 4'b0001, 4'h0, 16'h0001, 1'b0);
    tick();
    push_exp("lat_E3", 4'b0001, 4'h0, 16'h0001, 1'b1);

    // Arming: inputs high through reset in rising mode must not fire.
    EV_IN  = 4'hF;
    IRQ_EN = 4'h0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      push_exp("arm_high", 4'h0, 4'h0, 16'h0000, 1'b0);
    end

    // Arming: falling mode with inputs low, then a real 1->0 on ch2.
    EV_IN    = 4'h0;
    EDGE_SEL = 8'b01010101;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      tick();
      push_exp("arm_fall", 4'h0, 4'h0, 16'h0000, 1'b0);
    end
    EV_IN[2] = 1'b1;
    repeat (4) tick();
    push_exp("fall_rise_ignored", 4'h0, 4'h0, 16'h0000, 1'b0);
    EV_IN[2] = 1'b0;
    tick();
    tick();
    push_exp("fall_pre", 4'h0, 4'h0, 16'h0000, 1'b0);
    tick();
    push_exp("fall_ch2", 4'b0100, 4'h0, 16'h0100, 1'b0);

    // Overflow and saturation on ch1, then clear.
    EDGE_SEL = 8'h00;
    IRQ_EN   = 4'b0010;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      pulse(1, 2);
      if (k == 1) push_exp("sat_p1", 4'b0010, 4'h0, 16'h0010, 1'b1);
      if (k == 2) push_exp("sat_p2", 4'b0010, 4'b0010, 16'h0020, 1'b1);
    end
    push_exp("sat_p20", 4'b0010, 4'b0010, 16'h00F0, 1'b1);
    CLR = 4'b0010;
    tick();
    CLR = 4'h0;
    push_exp("clr_ch1", 4'h0, 4'h0, 16'h0000, 1'b1);
    tick();
    push_exp("clr_irq", 4'h0, 4'h0, 16'h0000, 1'b0);

    // Clear/set collision on ch3 with CNT=7.
    IRQ_EN = 4'h0;
    do_reset();
    repeat (7) pulse(3, 2);
    push_exp("coll_pre", 4'b1000, 4'b1000, 16'h7000, 1'b0);
    EV_IN[3] = 1'b1;
    tick();
    tick();
    push_exp("coll_hold", 4'b1000, 4'b1000, 16'h7000, 1'b0);
    CLR = 4'b1000;
    tick();
    CLR = 4'h0;
    push_exp("coll_set_wins", 4'b1000, 4'h0, 16'h1000, 1'b0);
    EV_IN[3] = 1'b0;
    repeat (3) tick();
    push_exp("coll_after", 4'b1000, 4'h0, 16'h1000, 1'b0);

    // Modes on ch0: both edges, disabled, re-enable without stale edge.
    EDGE_SEL = 8'b00000010;
    do_reset();
    pulse(0, 5);
    push_exp("both_2", 4'b0001, 4'b0001, 16'h0002, 1'b0);
    EDGE_SEL = 8'b00000011;
    pulse(0, 5);
    push_exp("off_hold", 4'b0001, 4'b0001, 16'h0002, 1'b0);
    EDGE_SEL = 8'b00000010;
    repeat (5) tick();
    push_exp("reenable", 4'b0001, 4'b0001, 16'h0002, 1'b0);
    EDGE_SEL = 8'b00000011;
    EV_IN[0] = 1'b1;
    repeat (5) tick();
    EDGE_SEL = 8'b00000010;
    repeat (5) tick();
    push_exp("reenable_high", 4'b0001, 4'b0001, 16'h0002, 1'b0);
    EV_IN[0] = 1'b0;
    repeat (5) tick();
    push_exp("both_fall", 4'b0001, 4'b0001, 16'h0003, 1'b0);

    // Masking, simultaneous channels, mid-operation reset.
    EDGE_SEL = 8'h00;
    IRQ_EN   = 4'b1001;
    do_reset();
    EV_IN = 4'b0110;
    tick();
    tick();
    EV_IN = 4'h0;
    tick();
    tick();
    push_exp("mask_off", 4'b0110, 4'h0, 16'h0110, 1'b0);
    IRQ_EN = 4'b1101;
    tick();
    push_exp("mask_on", 4'b0110, 4'h0, 16'h0110, 1'b1);
    EV_IN = 4'hF;
    ARST  = 1'b1;
    tick();
    push_exp("midop_reset", 4'h0, 4'h0, 16'h0000, 1'b0);
    ARST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      push_exp("rearm", 4'h0, 4'h0, 16'h0000, 1'b0);
    end

    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_event_flags.md
Name: disp_event_flags

Overview:
Multi-channel sticky event-flag and interrupt block for the display subsystem. Each channel synchronises an asynchronous display-domain strobe (VS, HS, frame-end, underflow, ...) into ACLK and detects a per-channel selectable edge. Each detected event sets a sticky flag, bumps a saturating event counter and records overflow on missed clears. Flags are combined under an enable mask into one registered interrupt for the AXI-side CPU.

Parameters:
NUM_CH, 4, number of independent event channels (1..16)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
CNT_W, 4, width of each per-channel saturating event counter (1..16)

Ports:
ACLK  in  1  system clock
ARST  in  1  reset
EV_IN  in  NUM_CH  asynchronous event inputs, one per channel
EDGE_SEL  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled
IRQ_EN  in  NUM_CH  per-channel interrupt enable
CLR  in  NUM_CH  per-channel single-cycle clear strobe (FLAG, OVF, CNT)
FLAG  out  NUM_CH  sticky event flag
OVF  out  NUM_CH  sticky overflow: event detected while FLAG already set
CNT  out  NUM_CH*CNT_W  per-channel event count since last clear, channel i at [CNT_W*i +: CNT_W]
IRQ  out  1  registered OR of (FLAG & IRQ_EN)

Behaviour:
- Reset ARST is synchronous and active-high; clock is ACLK. All state updates on the rising edge of ACLK.
- Reset values: sync chain 0, edge-history 0, FLAG 0, OVF 0, CNT 0, IRQ 0, arm counter 0.
- Synchroniser: per channel, SYNC_STAGES-deep shift register. The last stage is s. The history register p holds s delayed by one cycle.
- Edge detect (combinational): rise = s & ~p; fall = ~s & p. det = rise, fall, rise|fall or 0 per EDGE_SEL.
- A change of EDGE_SEL takes effect in the same cycle. The mode change itself never produces det.
- Arming: after ARST deasserts, det is forced to 0 for the first SYNC_STAGES+1 cycles while the pipeline fills. An internal counter saturates at SYNC_STAGES+1 and gates det. This prevents spurious edges from reset state, for example falling mode with EV_IN held low.
- Latency: a new EV_IN level is first sampled at edge E. FLAG/CNT/OVF update at edge E+SYNC_STAGES. IRQ updates at E+SYNC_STAGES+1.
- Per-channel update priority, evaluated each cycle:
  - CLR=1 and det=1: FLAG<=1, OVF<=0, CNT<=1. The event is never lost and set wins over clear.
  - CLR=1 and det=0: FLAG<=0, OVF<=0, CNT<=0.
  - CLR=0, det=1, FLAG=0: FLAG<=1, CNT<=CNT+1 (saturating).
  - CLR=0, det=1, FLAG=1: OVF<=1, CNT<=CNT+1 (saturating).
  - Otherwise all hold.
- CNT saturates at 2^CNT_W-1. It never wraps to 0.
- Mode 11 (disabled) only blocks new detections. Existing FLAG/OVF/CNT hold and CLR still works. History p keeps tracking s, so re-enabling does not produce a stale edge.
- IRQ <= |(FLAG & IRQ_EN), using registered FLAG, hence one cycle after FLAG. IRQ_EN affects only IRQ, never FLAG/OVF/CNT.
- Channels are fully independent. Simultaneous events on several channels are all recorded in the same cycle.
- Reset mid-operation: all outputs return to reset values at the next edge and the arming window restarts.
- Input pulses shorter than one ACLK period may be missed; this is a source-side requirement. Events closer than 2 cycles apart in both-edge mode are each counted if both levels are sampled.

Test Plan:
Use NUM_CH=4, SYNC_STAGES=2, CNT_W=4.
1. Reset latency: release ARST, EV_IN[0] 0->1 sampled at edge E, EDGE_SEL[1:0]=00, IRQ_EN=0001 -> FLAG[0]=1 after E+2, CNT0=1, OVF[0]=0, IRQ=1 after E+3.
2. Arming: hold EV_IN=0000, EDGE_SEL all 01, release ARST -> FLAG stays 0000 for 50 cycles. A later 1->0 on EV_IN[2] -> FLAG[2]=1 and CNT2=1.
3. Overflow/saturation: 20 rising pulses on ch1 without CLR -> FLAG[1]=1, OVF[1]=1, CNT1=15 (saturated). CLR[1] pulse -> FLAG, OVF and CNT1 all 0.
4. Clear/set collision: CLR[3]=1 in the same cycle as det on ch3 with FLAG[3]=1, OVF[3]=1, CNT3=7 -> next cycle FLAG[3]=1, OVF[3]=0, CNT3=1.
5. Modes: ch0 both-edges with a 0->1->0 pulse of 5 cycles -> CNT0=2. Switch ch0 to 11 and repeat the pulse -> CNT0 stays 2. Switch back to 10 with no input change -> no new detection.
6. Masking/mid-op reset: FLAG=0110, IRQ_EN=1001 -> IRQ=0. Set IRQ_EN[2]=1 -> IRQ=1 the next cycle. Assert ARST for 1 cycle -> all outputs 0 next edge and the arming window restarts.
